// File: rtl/fila_pkg.sv
// Shared types and sizes for the serial-to-parallel front end of the 8x8-bit FIFO.
package fila_pkg;

    localparam int WORD_W      = 8;
    localparam int QUEUE_DEPTH = 8;

    typedef enum logic [1:0] {
        COLLECT,
        PARITY,
        READY
    } deser_state_t;

endpackage

// File: rtl/deserializador_if.sv
// Serial-in / word-out bundle between a bit source, deserializador and its consumer (FIFO enqueue side).
interface deserializador_if #(
    parameter int WIDTH  = fila_pkg::WORD_W,
    parameter int DROP_W = 4
);

    logic              data_in;
    logic              write_in;
    logic              ack_in;
    logic [WIDTH-1:0]  data_out;
    logic              data_ready;
    logic              status_out;
    logic [DROP_W-1:0] drop_cnt_out;
    logic              parity_err_out;

    modport master (
        output data_in, write_in, ack_in,
        input  data_out, data_ready, status_out, drop_cnt_out, parity_err_out
    );

    modport slave (
        input  data_in, write_in, ack_in,
        output data_out, data_ready, status_out, drop_cnt_out, parity_err_out
    );

endinterface

// File: rtl/deserializador_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, cleared only by async reset.
module sat_counter #(
    parameter int W = 4
) (
    input  logic         clock_10KHz,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clock_10KHz or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/deserializador.sv
// Collects WIDTH serial bits (MSB first) into a word and holds it until acknowledged.
// Optional even-parity check after the data bits when DESER_PARITY_EN is defined.
module deserializador
    import fila_pkg::*;
#(
    parameter int WIDTH  = WORD_W,
    parameter int DROP_W = 4
) (
    input  logic            clock_10KHz,
    input  logic            reset,
    deserializador_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    deser_state_t     state, next_state;
    logic [CNT_W-1:0] bit_cnt;
    // The top bit of the shift register is never read: it falls straight into data_out.
    logic [WIDTH-2:0] shreg;
    logic [WIDTH-1:0] word;
    logic             accept;
    logic             last_bit;
    logic             drop;
    logic             parity_bad;

    assign accept   = (state == COLLECT) && bus.write_in;
    assign last_bit = accept && (bit_cnt == CNT_W'(WIDTH - 1));
    assign drop     = (state == READY) && bus.write_in;

    always_comb begin
        next_state = state;
        parity_bad = 1'b0;
        case (state)
            COLLECT: begin
                if (last_bit) begin
`ifdef DESER_PARITY_EN
                    next_state = PARITY;
`else
                    next_state = READY;
`endif
                end
            end
`ifdef DESER_PARITY_EN
            PARITY: begin
                if (bus.write_in) begin
                    parity_bad = (bus.data_in != ^word);
                    next_state = parity_bad ? COLLECT : READY;
                end
            end
`endif
            READY: begin
                if (bus.ack_in) begin
                    next_state = COLLECT;
                end
            end
            default: next_state = COLLECT;
        endcase
    end

    always_ff @(posedge clock_10KHz or posedge reset) begin
        if (reset) begin
            state <= COLLECT;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clock_10KHz or posedge reset) begin
        if (reset) begin
            bit_cnt <= '0;
            shreg   <= '0;
            word    <= '0;
        end else if (accept) begin
            shreg <= {shreg[WIDTH-3:0], bus.data_in};
            if (last_bit) begin
                word    <= {shreg, bus.data_in};
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

`ifdef DESER_PARITY_EN
    logic parity_err;

    always_ff @(posedge clock_10KHz or posedge reset) begin
        if (reset) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= parity_bad;
        end
    end

    assign bus.parity_err_out = parity_err;
`else
    assign bus.parity_err_out = parity_bad;
`endif

    sat_counter #(.W(DROP_W)) u_drop_cnt (
        .clock_10KHz (clock_10KHz),
        .reset       (reset),
        .inc         (drop),
        .count       (bus.drop_cnt_out)
    );

    assign bus.data_out   = word;
    assign bus.data_ready = (state == READY);
    assign bus.status_out = (state == READY);

endmodule

// File: tb/tb_deserializador.sv
// Directed bench for deserializador; also exercises the parity path when DESER_PARITY_EN is defined.
`timescale 1us / 1ns
module tb_deserializador;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    deserializador_if #(.WIDTH(8), .DROP_W(4)) bus ();

    deserializador #(.WIDTH(8), .DROP_W(4)) dut (
        .clock_10KHz (clk),
        .reset       (reset),
        .bus         (bus)
    );

    always #50 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.write_in = 1'b0;
        bus.ack_in   = 1'b0;
        bus.data_in  = 1'b0;
    endtask

    // Drives one word MSB first (plus even parity when enabled); returns at the
    // falling edge after the final accepted bit with write_in low.
    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            bus.write_in = 1'b1;
            bus.data_in  = w[i];
        end
`ifdef DESER_PARITY_EN
        @(negedge clk);
        bus.data_in = ^w;
`endif
        @(negedge clk);
        idle();
    endtask

    task automatic ack_now();
        bus.ack_in = 1'b1;
        @(negedge clk);
        idle();
    endtask

    initial begin
        idle();
        repeat (2) @(negedge clk);
        check("rst_data_out", 32'(bus.data_out), 32'h00);
        check("rst_ready", 32'(bus.data_ready), 0);
        check("rst_status", 32'(bus.status_out), 0);
        check("rst_drop", 32'(bus.drop_cnt_out), 0);
        check("rst_perr", 32'(bus.parity_err_out), 0);
        reset = 1'b0;

        // 1: word A5
        @(negedge clk);
        send_word(8'hA5);
        check("t1_data", 32'(bus.data_out), 32'hA5);
        check("t1_ready", 32'(bus.data_ready), 1);
        check("t1_status", 32'(bus.status_out), 1);
        check("t1_perr", 32'(bus.parity_err_out), 0);

        // 3: bits arriving while READY are dropped and saturate the counter
        for (int i = 0; i < 20; i++) begin
            if (i == 1) check("t3_drop_first", 32'(bus.drop_cnt_out), 1);
            if (i == 15) check("t3_drop_15", 32'(bus.drop_cnt_out), 32'hF);
            bus.write_in = 1'b1;
            bus.data_in  = ~bus.data_in;
            @(negedge clk);
        end
        idle();
        check("t3_drop_sat", 32'(bus.drop_cnt_out), 32'hF);
        check("t3_data", 32'(bus.data_out), 32'hA5);
        check("t3_ready", 32'(bus.data_ready), 1);

        // 2: hold without ack, then ack
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("t2_hold_data", 32'(bus.data_out), 32'hA5);
            check("t2_hold_ready", 32'(bus.data_ready), 1);
        end
        ack_now();
        check("t2_ready_after_ack", 32'(bus.data_ready), 0);
        check("t2_status_after_ack", 32'(bus.status_out), 0);
        check("t2_data_kept", 32'(bus.data_out), 32'hA5);
        @(negedge clk);
        check("t2_stays_collect", 32'(bus.data_ready), 0);

        // 4: partial word then async reset mid-cycle
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.write_in = 1'b1;
            bus.data_in  = 1'b1;
        end
        @(negedge clk);
        idle();
        #10 reset = 1'b1;
        #5;
        check("t4_async_data", 32'(bus.data_out), 32'h00);
        check("t4_async_drop", 32'(bus.drop_cnt_out), 0);
        @(negedge clk);
        reset = 1'b0;
        send_word(8'h3C);
        check("t4_data", 32'(bus.data_out), 32'h3C);
        check("t4_ready", 32'(bus.data_ready), 1);
        ack_now();
        check("t4_ack", 32'(bus.data_ready), 0);

        // 5: back-to-back words, a bit offered during each ack cycle is dropped
        send_word(8'h01);
        check("t5_w0_data", 32'(bus.data_out), 32'h01);
        check("t5_w0_ready", 32'(bus.data_ready), 1);
        bus.write_in = 1'b1;
        bus.data_in  = 1'b1;
        ack_now();
        check("t5_w0_released", 32'(bus.data_ready), 0);
        check("t5_drop1", 32'(bus.drop_cnt_out), 1);
        send_word(8'hFF);
        check("t5_w1_data", 32'(bus.data_out), 32'hFF);
        check("t5_w1_ready", 32'(bus.data_ready), 1);
        bus.write_in = 1'b1;
        bus.data_in  = 1'b0;
        ack_now();
        check("t5_w1_released", 32'(bus.data_ready), 0);
        check("t5_drop2", 32'(bus.drop_cnt_out), 2);
        check("t5_perr", 32'(bus.parity_err_out), 0);

`ifdef DESER_PARITY_EN
        // 6: good parity reaches READY, bad parity pulses the error
        send_word(8'h03);
        check("t6_good_ready", 32'(bus.data_ready), 1);
        check("t6_good_data", 32'(bus.data_out), 32'h03);
        check("t6_good_perr", 32'(bus.parity_err_out), 0);
        ack_now();
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            bus.write_in = 1'b1;
            bus.data_in  = (i < 2);
        end
        @(negedge clk);
        idle();
        check("t6_parity_status", 32'(bus.status_out), 0);
        check("t6_parity_ready", 32'(bus.data_ready), 0);
        bus.write_in = 1'b1;
        bus.data_in  = 1'b1;
        @(negedge clk);
        idle();
        check("t6_bad_perr", 32'(bus.parity_err_out), 1);
        check("t6_bad_ready", 32'(bus.data_ready), 0);
        @(negedge clk);
        check("t6_perr_pulse_end", 32'(bus.parity_err_out), 0);
        check("t6_bad_status", 32'(bus.status_out), 0);
        check("t6_bad_drop", 32'(bus.drop_cnt_out), 2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
